// File: rtl/flasher_if.sv
// Control/status bundle between the flasher controller and its surroundings.
// The controller is the slave side; the stimulus/datapath side is the master.
interface flasher_if;
  logic        btn;
  logic        stop;
  logic [15:0] led_in;
  logic        tick;
  logic        flick;
  logic        busy;
  logic        fault;
  logic [7:0]  run_cnt;

  modport slave (
    input  btn, stop, led_in,
    output tick, flick, busy, fault, run_cnt
  );

  modport master (
    output btn, stop, led_in,
    input  tick, flick, busy, fault, run_cnt
  );
endinterface

// File: rtl/flasher_ctrl.sv
// Flasher run controller: debounced flick button, tick prescaler, run watchdog
// and a saturating count of completed runs.
module flasher_ctrl #(
  parameter int unsigned DIV       = 25000000,
  parameter int unsigned DEB       = 16,
  parameter int unsigned MAX_TICKS = 64
) (
  input  logic      clk,
  input  logic      reset,
  flasher_if.slave  bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW = $clog2(DEB + 1);
  localparam int unsigned TW = $clog2(MAX_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StFault} state_e;

  logic          sync1_q, sync2_q;
  logic          db_q, db_prev_q;
  logic [DW-1:0] deb_cnt_q;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] ticks_q;
  logic          tick_q, flick_q, busy_q, fault_q;
  logic [7:0]    run_cnt_q;

  logic press, led_full, last_tick;

  assign press     = db_q & ~db_prev_q;
  assign led_full  = (bus.led_in == 16'hFFFF);
  assign last_tick = (ticks_q == TW'(MAX_TICKS - 1));

  // Synchronizer and debouncer: a level is accepted after DEB consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= bus.btn;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      if (sync2_q == db_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DW'(DEB - 1)) begin
        db_q      <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  // tick_q is registered one cycle ahead: it is high exactly when presc_q == DIV-1 in StRun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      ticks_q   <= '0;
      tick_q    <= 1'b0;
      flick_q   <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!bus.stop && press) begin
            state_q <= StRun;
            presc_q <= '0;
            ticks_q <= '0;
            flick_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (bus.stop) begin
            state_q <= StIdle;
            presc_q <= '0;
            flick_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick_q && led_full) begin
            state_q <= StDone;
            presc_q <= '0;
            flick_q <= 1'b0;
          end else if (tick_q && last_tick) begin
            state_q <= StFault;
            presc_q <= '0;
            flick_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            flick_q <= press | (flick_q & ~tick_q);
            if (tick_q) begin
              presc_q <= '0;
              ticks_q <= ticks_q + 1'b1;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
            tick_q <= (presc_q == PW'(DIV - 2));
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!bus.stop && run_cnt_q != 8'hFF) begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end
        StFault: begin
          if (bus.stop) begin
            state_q <= StIdle;
            fault_q <= 1'b0;
          end else if (press) begin
            state_q <= StRun;
            presc_q <= '0;
            ticks_q <= '0;
            busy_q  <= 1'b1;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tick    = tick_q;
  assign bus.flick   = flick_q;
  assign bus.busy    = busy_q;
  assign bus.fault   = fault_q;
  assign bus.run_cnt = run_cnt_q;

endmodule

// File: tb/tb_flasher_ctrl.sv
// Randomized bench for flasher_ctrl against a cycle-level behavioural model
// built from run age, tick arithmetic and a sample-history debouncer.
module tb_flasher_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int MAX = 8;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MDone  = 2;
  localparam int MFault = 3;

  logic clk = 1'b0;
  logic reset;
  flasher_if bif ();

  flasher_ctrl #(.DIV(DIV), .DEB(DEB), .MAX_TICKS(MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_mode, m_age, m_run_cnt;
  bit m_flick, m_db, m_db_prev, m_s1, m_s2;
  bit s2_hist[$];
  int led_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return (m_mode == MRun) && ((m_age % DIV) == DIV - 1);
  endfunction

  task automatic model_edge();
    bit press, t, all_diff;
    if (!reset) begin
      m_mode = MIdle; m_age = 0; m_run_cnt = 0; m_flick = 0;
      m_db = 0; m_db_prev = 0; m_s1 = 0; m_s2 = 0;
      s2_hist.delete();
      return;
    end
    press = m_db && !m_db_prev;
    t     = m_tick();
    case (m_mode)
      MIdle: if (!bif.stop && press) begin m_mode = MRun; m_age = 0; m_flick = 1; end
      MRun: begin
        if (bif.stop) begin m_mode = MIdle; m_flick = 0; end
        else if (t && bif.led_in == 16'hFFFF) begin m_mode = MDone; m_flick = 0; end
        else if (t && (m_age / DIV) + 1 == MAX) begin m_mode = MFault; m_flick = 0; end
        else begin m_flick = press || (m_flick && !t); m_age++; end
      end
      MDone: begin
        if (!bif.stop && m_run_cnt < 255) m_run_cnt++;
        m_mode = MIdle;
      end
      default: begin
        if (bif.stop) m_mode = MIdle;
        else if (press) begin m_mode = MRun; m_age = 0; end
      end
    endcase
    // Level accepted once the last DEB synchronized samples all disagree with it.
    s2_hist.push_back(m_s2);
    if (s2_hist.size() > DEB) void'(s2_hist.pop_front());
    all_diff = (s2_hist.size() == DEB);
    foreach (s2_hist[i]) if (s2_hist[i] == m_db) all_diff = 0;
    m_db_prev = m_db;
    if (all_diff) begin m_db = !m_db; s2_hist.delete(); end
    m_s2 = m_s1;
    m_s1 = bif.btn;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tick",    bif.tick,    m_tick());
    check("flick",   bif.flick,   m_flick);
    check("busy",    bif.busy,    (m_mode == MRun) || (m_mode == MDone));
    check("fault",   bif.fault,   m_mode == MFault);
    check("run_cnt", bif.run_cnt, m_run_cnt);
    case (led_mode)
      0: bif.led_in = 16'h0000;
      1: bif.led_in = (m_mode == MRun && m_age / DIV == 2) ? 16'hFFFF : 16'h00F0;
      2: bif.led_in = 16'hFFFF;
      default: bif.led_in = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom) & 16'h7FFF;
    endcase
  endtask

  task automatic press();
    bif.btn = 1'b1;
    repeat (7) step();
    bif.btn = 1'b0;
    repeat (6) step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && m_mode != MIdle; i++) step();
  endtask

  initial begin
    int n, gap, ticks;
    reset = 1'b0; bif.btn = 1'b0; bif.stop = 1'b0; bif.led_in = '0; led_mode = 0;
    repeat (3) step();
    reset = 1'b1;
    check("rst_busy", bif.busy, 0);
    check("rst_run_cnt", bif.run_cnt, 0);

    // Clean press, completion on the 3rd tick
    led_mode = 1;
    bif.btn = 1'b1;
    n = 0;
    while (!bif.flick && n < 20) begin step(); n++; end
    check("flick_latency", n, 6);
    check("busy_in_run", bif.busy, 1);
    repeat (4) step();
    bif.btn = 1'b0;
    for (int i = 0; i < 40 && !bif.tick; i++) step();
    gap = 0;
    do begin step(); gap++; end while (!bif.tick && gap < 40);
    check("tick_period", gap, DIV);
    wait_idle();
    step();
    check("run_cnt_first", bif.run_cnt, 1);
    check("busy_after_done", bif.busy, 0);
    repeat (10) step();

    // Bounce: toggle every cycle
    for (int i = 0; i < 10; i++) begin bif.btn = ~bif.btn; step(); end
    bif.btn = 1'b0;
    repeat (15) step();
    check("bounce_flick", bif.flick, 0);
    check("bounce_busy", bif.busy, 0);

    // Watchdog
    led_mode = 0;
    bif.btn = 1'b1;
    ticks = 0;
    for (int i = 0; i < 200 && !bif.fault; i++) begin
      step();
      if (i == 7) bif.btn = 1'b0;
      if (bif.tick) ticks++;
    end
    check("wd_fault", bif.fault, 1);
    check("wd_ticks", ticks, MAX);
    press();
    check("wd_clear_fault", bif.fault, 0);
    check("wd_rerun_busy", bif.busy, 1);
    bif.stop = 1'b1; step(); bif.stop = 1'b0;
    check("stop_run_idle", bif.busy, 0);
    repeat (8) step();

    // stop and all-on frame on the same tick cycle
    press();
    for (int i = 0; i < 40 && !m_tick(); i++) step();
    bif.stop = 1'b1; bif.led_in = 16'hFFFF;
    step();
    bif.stop = 1'b0;
    step();
    check("stop_done_busy", bif.busy, 0);
    check("stop_done_cnt", bif.run_cnt, 1);

    // Reach run_cnt=5, then reset mid-run
    led_mode = 2;
    for (int i = 0; i < 10 && m_run_cnt < 5; i++) begin press(); wait_idle(); end
    step();
    check("run_cnt_five", bif.run_cnt, 5);
    led_mode = 0;
    press();
    check("pre_rst_busy", bif.busy, 1);
    reset = 1'b0; step(); reset = 1'b1;
    check("mid_rst_cnt", bif.run_cnt, 0);
    check("mid_rst_busy", bif.busy, 0);
    ticks = 0;
    for (int i = 0; i < 2 * DIV; i++) begin step(); if (bif.tick) ticks++; end
    check("no_tick_after_rst", ticks, 0);

    // Random phase
    led_mode = 3;
    for (int seg = 0; seg < 250; seg++) begin
      bif.btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) begin
        bif.stop = ($urandom_range(0, 19) == 0);
        reset    = ($urandom_range(0, 199) != 0);
        step();
      end
    end
    bif.stop = 1'b0; reset = 1'b1; bif.btn = 1'b0;
    repeat (10) step();

    // Saturation of run_cnt
    reset = 1'b0; step(); reset = 1'b1;
    led_mode = 2;
    repeat (256) begin press(); wait_idle(); end
    step();
    check("run_cnt_sat", bif.run_cnt, 255);
    press(); wait_idle(); step();
    check("run_cnt_hold", bif.run_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/flasher_ctrl.md
FLASHER_CTRL -- requirements
Module: flasher_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 25000000, meaning system-clock cycles per tick (DIV >= 2).
REQ-002 SHALL have parameter DEB, default 16, meaning consecutive stable cycles needed to accept a button level (DEB >= 1).
REQ-003 SHALL have parameter MAX_TICKS, default 64, meaning the watchdog limit in ticks for one run.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-006 SHALL have port btn, input, 1, raw asynchronous flick button, active-high.
REQ-007 SHALL have port stop, input, 1, synchronous abort request, active-high.
REQ-008 SHALL have port led_in, input, 16, LED bar returned from the flasher datapath.
REQ-009 SHALL have port tick, output, 1, one-cycle clock-enable strobe that advances the flasher.
REQ-010 SHALL have port flick, output, 1, stretched flick request to the flasher.
REQ-011 SHALL have port busy, output, 1, high while a run is in progress.
REQ-012 SHALL have port fault, output, 1, watchdog-expired flag.
REQ-013 SHALL have port run_cnt, output, 8, count of completed runs.

Function
REQ-014 SHALL pass btn through a 2-flop synchronizer, then debounce: btn_db changes only after the synced level differs from btn_db for DEB consecutive cycles; any bounce restarts the count.
REQ-015 SHALL define press as a 0->1 transition of btn_db, lasting one cycle.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE, FAULT.
REQ-017 In IDLE: prescaler held at 0, tick=0, busy=0. A press moves the FSM to RUN and sets flick.
REQ-018 In RUN: busy=1. The prescaler counts 0..DIV-1 and wraps. tick=1 exactly in the cycle the prescaler equals DIV-1, so the first tick comes DIV cycles after entering RUN.
REQ-019 flick set: on the cycle after any press in IDLE or RUN. flick clear: on the cycle after a tick cycle in which flick was 1. A press coinciding with that clearing tick keeps flick=1.
REQ-020 In RUN, each tick increments an internal tick counter, which is cleared on entry to RUN.
REQ-021 In RUN, on a tick cycle with led_in == 16'hFFFF (the flasher's final all-on frame), the FSM goes to DONE.
REQ-022 In RUN, if the tick counter reaches MAX_TICKS without completion, the FSM goes to FAULT.
REQ-023 DONE lasts exactly one cycle with busy=1. It increments run_cnt, saturating at 255, then returns to IDLE.
REQ-024 In FAULT: fault=1, busy=0, tick=0, flick=0. A press clears fault and goes to RUN; stop goes to IDLE and clears fault.
REQ-025 stop in RUN or DONE forces IDLE next cycle, clears flick, and leaves run_cnt unchanged.
REQ-026 Priority in one cycle: reset > stop > completion > watchdog. Completion and watchdog together means DONE.
REQ-027 Presses in DONE are ignored.

Reset
REQ-028 When reset=0 at a clock edge, the block SHALL go to IDLE with tick=0, flick=0, busy=0, fault=0, run_cnt=0; prescaler, tick counter, synchronizer and debounce state are cleared.
REQ-029 Reset mid-run SHALL abort without incrementing run_cnt.

Verification (DIV=4, DEB=3, MAX_TICKS=8)
REQ-030 Clean press: btn held high 10 cycles -> flick=1 exactly 6 cycles after the btn rise (2 sync + 3 debounce + 1); busy=1; tick pulses every 4 cycles.
REQ-031 Bounce: btn toggling every cycle for 10 cycles, then low -> no press, flick=0, FSM stays IDLE.
REQ-032 Completion: led_in=16'hFFFF on the 3rd tick -> DONE for 1 cycle, run_cnt 0->1, busy=0 next cycle; 256 runs -> run_cnt=255.
REQ-033 Watchdog: led_in=0 during RUN -> fault=1 after the 8th tick; next press -> fault=0, RUN.
REQ-034 stop and led_in=16'hFFFF on the same tick cycle -> IDLE, run_cnt unchanged.
REQ-035 reset=0 for one cycle mid-RUN with run_cnt=5 -> all outputs 0, run_cnt=0, next tick absent.
